imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 129 ++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Byte-stream program loader: takes a 32-bit little-endian length followed by
// the payload, packs it into 32-bit words and writes them to instruction memory.
module imem_loader #(
  parameter int          ADDRESS_WIDTH = 32,
  parameter int unsigned BASE_ADDR     = 0,
  parameter int unsigned MAX_BYTES     = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic                     we,
  output logic [ADDRESS_WIDTH-1:0] WA,
  output logic [31:0]              WD,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     cpu_hold
);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    LOAD,
    WRITE,
    DONE,
    ERR
  } state_t;

  state_t                   state_q, state_d;
  logic [1:0]               len_cnt_q;
  logic [31:0]              len_q;
  logic [31:0]              rcv_q;
  logic [31:0]              word_q;
  logic [ADDRESS_WIDTH-1:0] wptr_q;

  logic        xfer;
  logic [31:0] len_full;
  logic [31:0] rcv_next;

  assign in_ready = (state_q == LEN) || (state_q == LOAD);
  assign xfer     = in_valid && in_ready;
  // The 4th length byte is still on in_data when the next state is chosen.
  assign len_full = {in_data, len_q[23:0]};
  assign rcv_next = rcv_q + 32'd1;

  assign we       = (state_q == WRITE);
  assign WA       = we ? wptr_q : '0;
  assign WD       = we ? word_q : '0;
  assign busy     = (state_q == LEN) || (state_q == LOAD) || (state_q == WRITE);
  assign done     = (state_q == DONE);
  assign err      = (state_q == ERR);
  assign cpu_hold = busy;

  // NOTE: every always_comb target gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) state_d = LEN;
      end
      LEN: begin
        if (xfer && (len_cnt_q == 2'd3)) begin
          if (len_full == 32'd0)           state_d = DONE;
          else if (len_full > MAX_BYTES)   state_d = ERR;
          else                             state_d = LOAD;
        end
      end
      LOAD: begin
        if (xfer && ((rcv_q[1:0] == 2'd3) || (rcv_next == len_q))) state_d = WRITE;
      end
      WRITE: begin
        state_d = (rcv_q < len_q) ? LOAD : DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_cnt_q <= 2'd0;
      len_q     <= 32'd0;
      rcv_q     <= 32'd0;
      word_q    <= 32'd0;
      wptr_q    <= '0;
    end else begin
      case (state_q)
        IDLE, DONE, ERR: begin
          if (start) begin
            len_cnt_q <= 2'd0;
            len_q     <= 32'd0;
            rcv_q     <= 32'd0;
            word_q    <= 32'd0;
            wptr_q    <= ADDRESS_WIDTH'(BASE_ADDR);
          end
        end
        LEN: begin
          if (xfer) begin
            len_q[{len_cnt_q, 3'b000} +: 8] <= in_data;
            len_cnt_q                       <= len_cnt_q + 2'd1;
          end
        end
        LOAD: begin
          if (xfer) begin
            word_q[{rcv_q[1:0], 3'b000} +: 8] <= in_data;
            rcv_q                             <= rcv_next;
          end
        end
        WRITE: begin
          // Clearing here leaves unfilled lanes of a short final word at zero.
          wptr_q <= wptr_q + ADDRESS_WIDTH'(4);
          word_q <= 32'd0;
        end
        default: ;
      endcase
    end
  end

endmodule
